multicore_run_controller: RTL

Parametrised run-sequencing and memory-arbitration controller for the multicore matrix processor. It sequences instruction load, data load, execution, result transmit and finish for CORE_COUNT cores. It multiplexes instruction and data memory ports between the UART memory interfaces and the lead core, and completes execution only once every core has signalled done. Compared with the fixed 4-core top level it adds sticky per-core done tracking, an execution timeout and error state, a rerun path that keeps the loaded program, and parametrised capture of the transfer bounds.

---
 rtl/multicore_run_controller.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/multicore_run_controller.sv
// Run sequencer and memory arbiter for the multicore matrix processor.
// Steps load/execute/transmit for CORE_COUNT cores and muxes memory ports between UART and lead core.
module multicore_run_controller #(
  parameter int CORE_COUNT     = 4,
  parameter int REG_WIDTH      = 12,
  parameter int DMEM_AW        = 12,
  parameter int IMEM_AW        = 8,
  parameter int TIME_WIDTH     = 26,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int RX_END_LOC     = 7,
  parameter int TX_START_LOC   = 5,
  parameter int TX_END_LOC     = 8,
  parameter int DW             = CORE_COUNT * REG_WIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          rerun,
  input  logic                          uart_imem_received,
  input  logic                          uart_dmem_received,
  input  logic                          uart_dmem_transmitted,
  input  logic                          uart_rx_byte_valid,
  output logic                          ins_byte_valid,
  output logic                          data_byte_valid,
  input  logic                          uart_imem_wr_en,
  input  logic [IMEM_AW-1:0]            uart_imem_addr,
  input  logic                          uart_dmem_wr_en,
  input  logic [DMEM_AW-1:0]            uart_dmem_addr,
  input  logic [DW-1:0]                 uart_dmem_data,
  input  logic [CORE_COUNT-1:0]         proc_dmem_wr_en,
  input  logic [CORE_COUNT*DMEM_AW-1:0] proc_dmem_addr,
  input  logic [CORE_COUNT*IMEM_AW-1:0] proc_imem_addr,
  input  logic [DW-1:0]                 proc_dmem_data,
  input  logic [CORE_COUNT-1:0]         core_done,
  output logic                          imem_wr_en,
  output logic [IMEM_AW-1:0]            imem_addr,
  output logic                          dmem_wr_en,
  output logic [DMEM_AW-1:0]            dmem_addr,
  output logic [DW-1:0]                 dmem_data,
  output logic                          process_start,
  output logic                          tx_start,
  output logic [REG_WIDTH-1:0]          rx_end_addr,
  output logic [REG_WIDTH-1:0]          tx_start_addr,
  output logic [REG_WIDTH-1:0]          tx_end_addr,
  output logic [2:0]                    state,
  output logic [TIME_WIDTH-1:0]         cycle_count,
  output logic                          timeout_err
);

  // state    | meaning
  // IDLE     | waiting for start after reset
  // RX_IMEM  | UART loading instruction memory
  // RX_DMEM  | UART loading data memory, transfer bounds captured here
  // EXEC     | cores running, lead core owns both memories
  // TX_DMEM  | UART transmitting results
  // FINISH   | run complete; start reloads everything, rerun keeps the program
  // ERROR    | execution timed out
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RX_IMEM = 3'd1,
    S_RX_DMEM = 3'd2,
    S_EXEC    = 3'd3,
    S_TX_DMEM = 3'd4,
    S_FINISH  = 3'd5,
    S_ERROR   = 3'd6
  } state_t;

  localparam logic [DMEM_AW-1:0]    LP_RX_END   = DMEM_AW'(RX_END_LOC);
  localparam logic [DMEM_AW-1:0]    LP_TX_START = DMEM_AW'(TX_START_LOC);
  localparam logic [DMEM_AW-1:0]    LP_TX_END   = DMEM_AW'(TX_END_LOC);
  localparam logic [TIME_WIDTH-1:0] LP_TO_LAST  =
    TIME_WIDTH'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t                  r_state;
  logic [CORE_COUNT-1:0]   r_done_seen;
  logic [TIME_WIDTH-1:0]   r_cycle_count;
  logic                    r_timeout_err;
  logic [REG_WIDTH-1:0]    r_rx_end_addr;
  logic [REG_WIDTH-1:0]    r_tx_start_addr;
  logic [REG_WIDTH-1:0]    r_tx_end_addr;

  logic                    w_in_exec;
  logic                    w_all_done;
  logic                    w_process_start;
  logic                    w_tx_start;
  logic                    w_timeout;
  logic                    w_unused;

  // Done pulses from different cores may land in different cycles; the sticky copy covers that.
  assign w_in_exec       = (r_state == S_EXEC);
  assign w_all_done      = &(r_done_seen | core_done);
  assign w_process_start = (r_state == S_RX_DMEM) & uart_dmem_received;
  assign w_tx_start      = w_in_exec & w_all_done;
  assign w_timeout       = (TIMEOUT_CYCLES != 0) & w_in_exec & ~w_all_done &
                           (r_cycle_count == LP_TO_LAST);

  // Only the lead core's address and write enable reach the shared memories.
  assign w_unused = ^{proc_dmem_wr_en, proc_dmem_addr, proc_imem_addr, uart_dmem_data};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_done_seen     <= '0;
      r_cycle_count   <= '0;
      r_timeout_err   <= 1'b0;
      r_rx_end_addr   <= '0;
      r_tx_start_addr <= '0;
      r_tx_end_addr   <= '0;
    end else begin
      case (r_state)
        S_IDLE:    if (start) r_state <= S_RX_IMEM;
        S_RX_IMEM: if (uart_imem_received) r_state <= S_RX_DMEM;
        S_RX_DMEM: if (uart_dmem_received) r_state <= S_EXEC;
        S_EXEC: begin
          if (w_all_done) begin
            r_state <= S_TX_DMEM;
          end else if (w_timeout) begin
            r_state       <= S_ERROR;
            r_timeout_err <= 1'b1;
          end
        end
        S_TX_DMEM: if (uart_dmem_transmitted) r_state <= S_FINISH;
        S_FINISH: begin
          if (start)      r_state <= S_RX_IMEM;
          else if (rerun) r_state <= S_RX_DMEM;
        end
        S_ERROR: begin
          if (start) begin
            r_state       <= S_RX_IMEM;
            r_timeout_err <= 1'b0;
          end
        end
        default:   r_state <= S_IDLE;
      endcase

      if (w_process_start)
        r_done_seen <= '0;
      else if (w_in_exec)
        r_done_seen <= r_done_seen | core_done;

      if (w_process_start)
        r_cycle_count <= '0;
      else if (w_in_exec && (r_cycle_count != '1))
        r_cycle_count <= r_cycle_count + 1'b1;

      if ((r_state == S_RX_DMEM) && uart_dmem_wr_en) begin
        if (uart_dmem_addr == LP_RX_END)
          r_rx_end_addr <= uart_dmem_data[REG_WIDTH-1:0];
        else if (uart_dmem_addr == LP_TX_START)
          r_tx_start_addr <= uart_dmem_data[REG_WIDTH-1:0];
        else if (uart_dmem_addr == LP_TX_END)
          r_tx_end_addr <= uart_dmem_data[REG_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    imem_wr_en = 1'b0;
    imem_addr  = '0;
    dmem_wr_en = 1'b0;
    dmem_addr  = '0;
    dmem_data  = '0;
    case (r_state)
      S_RX_IMEM: begin
        imem_wr_en = uart_imem_wr_en;
        imem_addr  = uart_imem_addr;
      end
      S_RX_DMEM, S_TX_DMEM: begin
        dmem_wr_en = uart_dmem_wr_en;
        dmem_addr  = uart_dmem_addr;
        dmem_data  = uart_dmem_data;
      end
      S_EXEC: begin
        imem_addr  = proc_imem_addr[IMEM_AW-1:0];
        dmem_wr_en = proc_dmem_wr_en[0];
        dmem_addr  = proc_dmem_addr[DMEM_AW-1:0];
        dmem_data  = proc_dmem_data;
      end
      default: ;
    endcase
  end

  assign ins_byte_valid  = uart_rx_byte_valid & (r_state == S_RX_IMEM);
  assign data_byte_valid = uart_rx_byte_valid & (r_state == S_RX_DMEM);
  assign process_start   = w_process_start;
  assign tx_start        = w_tx_start;
  assign rx_end_addr     = r_rx_end_addr;
  assign tx_start_addr   = r_tx_start_addr;
  assign tx_end_addr     = r_tx_end_addr;
  assign state           = r_state;
  assign cycle_count     = r_cycle_count;
  assign timeout_err     = r_timeout_err;

endmodule
